// File: rtl/rwt_dac_stream_feeder.sv
// Purpose : buffers 64-bit (4 x 16-bit) sample words from an AXI-Stream source and plays them
//           out to a DAC core on request, with priming, per-lane masking and underflow tracking.
// Latency : a request on edge N pops the FIFO head into dac_data on that same edge N.
//           The sink samples the new word at edge N+1.
// Backpr. : s_axis_tready = !full, regardless of state. Requests are ignored until the FIFO is primed.
// Ports   : dac_clk/dac_rstn             - clock, async active-low reset
//           s_axis_tdata/tvalid/tready   - upstream sample words
//           dac_enable/dac_valid         - per-lane enable and sample request from the DAC core
//           dac_data                     - registered, lane-masked samples
//           flush                        - empties the FIFO
//           underflow/underflow_count/underflow_clr - sticky flag, saturating count, clear pulse
//           fifo_level                   - current occupancy 0..2**FIFO_DEPTH_LOG2
module rwt_dac_stream_feeder #(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int PRIME_LEVEL     = 8,
  parameter bit UNDERFLOW_HOLD  = 1'b0
) (
  input  logic                     dac_clk,
  input  logic                     dac_rstn,
  input  logic [63:0]              s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [3:0]               dac_enable,
  input  logic [3:0]               dac_valid,
  output logic [63:0]              dac_data,
  input  logic                     flush,
  output logic                     underflow,
  output logic [15:0]              underflow_count,
  input  logic                     underflow_clr,
  output logic [FIFO_DEPTH_LOG2:0] fifo_level
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int LW    = FIFO_DEPTH_LOG2 + 1;
  localparam logic [LW-1:0]              LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0]              LVL_PRIME = LW'(PRIME_LEVEL);
  localparam logic [LW-1:0]              LVL_ONE   = LW'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE   = FIFO_DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    UNDER = 2'd3
  } state_t;

  state_t                     state, state_nxt;
  logic [63:0]                mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0]              level, level_nxt;
  logic [63:0]                head, head_masked, data_nxt;
  logic                       full, empty, push, pop, uf_evt, req, en_any;
  logic                       uf_nxt;
  logic [15:0]                cnt_nxt;

  assign full          = (level == LVL_FULL);
  assign empty         = (level == '0);
  assign s_axis_tready = !full;
  // flush discards any push presented on the same edge
  assign push          = s_axis_tvalid && !full && !flush;
  assign en_any        = |dac_enable;
  assign req           = |dac_valid;
  assign head          = mem[rd_ptr];
  assign fifo_level    = level;

  // Disabled lanes are driven as zero rather than stale FIFO data
  always_comb begin
    head_masked = '0;
    for (int i = 0; i < 4; i++) begin
      if (dac_enable[i]) head_masked[16*i +: 16] = head[16*i +: 16];
    end
  end

  // Next state, pop decision and next output word
  always_comb begin
    state_nxt = state;
    data_nxt  = dac_data;
    pop       = 1'b0;
    uf_evt    = 1'b0;
    if (!en_any) begin
      // Core disabled: park in IDLE, keep FIFO contents
      state_nxt = IDLE;
      data_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = PRIME;
          data_nxt  = '0;
        end
        PRIME: begin
          if (level >= LVL_PRIME) state_nxt = RUN;
        end
        RUN: begin
          if (req) begin
            if (empty) begin
              uf_evt    = 1'b1;
              state_nxt = UNDER;
              if (!UNDERFLOW_HOLD) data_nxt = '0;
            end else if (!flush) begin
              pop      = 1'b1;
              data_nxt = head_masked;
            end
          end
        end
        UNDER: begin
          state_nxt = PRIME;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    level_nxt = level;
    if (flush) begin
      level_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   level_nxt = level + LVL_ONE;
        2'b01:   level_nxt = level - LVL_ONE;
        default: level_nxt = level;
      endcase
    end
  end

  // Clear is applied first so a coincident underflow event leaves count = 1
  always_comb begin
    uf_nxt  = underflow;
    cnt_nxt = underflow_count;
    if (underflow_clr) begin
      uf_nxt  = 1'b0;
      cnt_nxt = '0;
    end
    if (uf_evt) begin
      uf_nxt = 1'b1;
      if (cnt_nxt != 16'hFFFF) cnt_nxt = cnt_nxt + 16'd1;
    end
  end

  always_ff @(posedge dac_clk or negedge dac_rstn) begin
    if (!dac_rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge dac_clk or negedge dac_rstn) begin
    if (!dac_rstn) begin
      level           <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      dac_data        <= '0;
      underflow       <= 1'b0;
      underflow_count <= '0;
    end else begin
      level           <= level_nxt;
      dac_data        <= data_nxt;
      underflow       <= uf_nxt;
      underflow_count <= cnt_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Storage needs no reset; validity is tracked by level and the pointers
  always_ff @(posedge dac_clk) begin
    if (push) mem[wr_ptr] <= s_axis_tdata;
  end

endmodule

// File: doc/rwt_dac_stream_feeder.md
RWT_DAC_STREAM_FEEDER -- requirements
Module: rwt_dac_stream_feeder

Interface
REQ-001 Parameter FIFO_DEPTH_LOG2, default 4, meaning FIFO holds 2**FIFO_DEPTH_LOG2 64-bit sample words.
REQ-002 Parameter PRIME_LEVEL, default 8, meaning the FIFO level (1..depth) required before sample playout starts.
REQ-003 Parameter UNDERFLOW_HOLD, default 0, meaning 0 = output zeros on underflow and 1 = repeat the last word.
REQ-004 The block SHALL use one clock; reset SHALL be asynchronous and active-low, on the ports below.
REQ-005 dac_clk  input  1  sample clock; all logic on its rising edge.
REQ-006 dac_rstn  input  1  asynchronous active-low reset.
REQ-007 s_axis_tdata  input  64  four 16-bit samples; channel i in bits [16i+15:16i].
REQ-008 s_axis_tvalid  input  1  upstream word valid.
REQ-009 s_axis_tready  output  1  FIFO can accept a word.
REQ-010 dac_enable  input  4  per-channel enable from the DAC core.
REQ-011 dac_valid  input  4  per-channel sample request from the DAC core; any bit set is one request.
REQ-012 dac_data  output  64  registered samples to the DAC core.
REQ-013 flush  input  1  synchronous pulse that empties the FIFO.
REQ-014 underflow  output  1  sticky underflow flag.
REQ-015 underflow_count  output  16  saturating underflow event count.
REQ-016 underflow_clr  input  1  synchronous pulse that clears underflow and underflow_count.
REQ-017 fifo_level  output  FIFO_DEPTH_LOG2+1  current FIFO occupancy.

Function
REQ-018 The FIFO write rule SHALL be: s_axis_tready = !full, and a push occurs when tvalid && tready; tready SHALL be independent of state.
REQ-019 A simultaneous push and pop SHALL leave fifo_level unchanged; a push when full SHALL be impossible by REQ-018.
REQ-020 flush SHALL set fifo_level to 0 next edge and SHALL drop any same-cycle push and pop.
REQ-021 The state machine SHALL have the states IDLE, PRIME, RUN and UNDER.
REQ-022 In any state, dac_enable == 0 SHALL force IDLE on the next edge, and FIFO contents SHALL be retained.
REQ-023 IDLE -> PRIME SHALL occur when dac_enable != 0.
REQ-024 PRIME -> RUN SHALL occur when fifo_level >= PRIME_LEVEL.
REQ-025 In IDLE and PRIME, dac_data SHALL be 0 and no pop SHALL occur; dac_valid SHALL be ignored.
REQ-026 In RUN, for a request (dac_valid != 0) with the FIFO non-empty, the block SHALL pop the head and set dac_data <= head with 16-bit lane i zeroed where dac_enable[i] = 0.
REQ-027 The latency from a requesting edge to dac_data update SHALL be exactly that edge; the data SHALL be visible to the sink at the next edge.
REQ-028 In RUN with no request, dac_data SHALL hold.
REQ-029 In RUN, a request with the FIFO empty SHALL cause the transition to UNDER.
REQ-030 On that underflow edge, dac_data SHALL become 0 (UNDERFLOW_HOLD = 0) or hold (UNDERFLOW_HOLD = 1).
REQ-031 On that underflow edge, underflow SHALL become 1 and underflow_count SHALL increment, saturating at 16'hFFFF.
REQ-032 UNDER SHALL last one cycle and then go to PRIME (re-prime); dac_data SHALL follow REQ-030 while in UNDER and PRIME.
REQ-033 underflow_clr SHALL clear underflow and underflow_count; when it coincides with an underflow event, the event SHALL win (underflow = 1, count = 1).
REQ-034 The fifo_level arithmetic SHALL be exact, with no wrap, over the range 0..2**FIFO_DEPTH_LOG2; pointers SHALL wrap modulo the depth.

Reset
REQ-035 While dac_rstn = 0, the block SHALL be in state IDLE with fifo_level = 0.
REQ-036 While dac_rstn = 0, the outputs SHALL be: s_axis_tready = 1, dac_data = 0, underflow = 0, underflow_count = 0.
REQ-037 Reset asserted mid-RUN SHALL discard FIFO contents immediately, i.e. asynchronously.
REQ-038 After release, the block SHALL operate from the first rising edge with dac_rstn = 1.

Verification
REQ-039 Prime/playout: depth 16, PRIME_LEVEL 8; push 8 words 0x0004_0003_0002_0001 + k; enable = 4'hF; valid every cycle -> RUN after level 8, dac_data steps k = 0..7 in order, then UNDER on the 9th request.
REQ-040 Channel mask: dac_enable = 4'b0101, head 0x4444_3333_2222_1111 -> dac_data = 0x0000_3333_0000_1111.
REQ-041 Full/back-pressure: push 17 words with no requests -> tready = 0 at level 16, the 17th word is accepted only after one pop, and fifo_level never exceeds 16.
REQ-042 Underflow: run the FIFO dry with valid held high -> underflow = 1, count = 1, dac_data = 0, state PRIME; refill 8 words -> RUN resumes.
REQ-043 Clear/saturate: clr on the same cycle as an underflow -> count = 1; with count preloaded to 16'hFFFF, a further underflow -> count stays 16'hFFFF.
REQ-044 Reset mid-RUN with level 5 -> fifo_level = 0, dac_data = 0, IDLE asynchronously; enable still high -> PRIME on the first clock edge after release.
